// File: rtl/nco_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nco_mixer_pkg
// Brief    : Shared types, LFSR constants and sine quantisation for nco_mixer.
// Revision : 1.0 - initial release
// ============================================================================
package nco_mixer_pkg;

    localparam int c_DATA_WIDTH  = 16;
    localparam int c_LUT_WIDTH   = 16;
    localparam int c_PHASE_WIDTH = 32;
    localparam int c_LUT_ADDR    = 10;

    typedef logic        [c_PHASE_WIDTH-1:0] phase_t;
    typedef logic signed [c_DATA_WIDTH-1:0]  sample_t;
    typedef logic signed [c_LUT_WIDTH-1:0]   amp_t;
    typedef logic        [15:0]              lfsr_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam lfsr_t  c_LFSR_SEED = 16'hACE1;
    localparam lfsr_t  c_LFSR_TAPS = 16'hB400;
    localparam longint c_PI_Q30    = 64'sd3373259426;

    // round((2^(amp_width-1)-1) * sin(pi/2 * idx / 2^quarter_bits)), Taylor series in Q30
    function automatic longint lut_quantise(input int idx, input int quarter_bits,
                                            input int amp_width);
        longint x;
        longint term;
        longint sum;
        longint peak;
        x    = (longint'(idx) * c_PI_Q30) >>> (quarter_bits + 1);
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        peak = (longint'(1) <<< (amp_width - 1)) - 1;
        return (sum * peak + (longint'(1) <<< 29)) >>> 30;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_lut.sv
`default_nettype none
// ============================================================================
// Module   : sine_lut
// Brief    : Quarter-wave sine/cosine table with quadrant folding, one register.
// Revision : 1.0 - initial release
// ============================================================================
module sine_lut
    import nco_mixer_pkg::*;
#(
    parameter int LUT_WIDTH = c_LUT_WIDTH,
    parameter int LUT_ADDR  = c_LUT_ADDR
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 i_en,
    input  logic [LUT_ADDR-1:0]  i_addr,
    output logic [LUT_WIDTH-1:0] o_cos,
    output logic [LUT_WIDTH-1:0] o_sin
);

    localparam int                   c_QB      = LUT_ADDR - 2;
    localparam int                   c_DEPTH   = 1 << c_QB;
    localparam logic [LUT_WIDTH-1:0] c_PEAK    = {1'b0, {(LUT_WIDTH-1){1'b1}}};
    localparam logic [LUT_ADDR-1:0]  c_QUARTER = LUT_ADDR'(c_DEPTH);

    logic [LUT_WIDTH-1:0] w_rom [c_DEPTH];
    logic [LUT_ADDR-1:0]  w_addr [2];
    logic [LUT_WIDTH-1:0] w_val [2];

    for (genvar i = 0; i < c_DEPTH; i++) begin : g_rom
        localparam logic [LUT_WIDTH-1:0] c_ENTRY = LUT_WIDTH'(lut_quantise(i, c_QB, LUT_WIDTH));
        assign w_rom[i] = c_ENTRY;
    end

    // cos(phi) is read as sin(phi + quarter turn)
    assign w_addr[0] = i_addr + c_QUARTER;
    assign w_addr[1] = i_addr;

    for (genvar k = 0; k < 2; k++) begin : g_fold
        logic [c_QB-1:0]      w_idx;
        logic [c_QB-1:0]      w_mirror;
        logic [LUT_WIDTH-1:0] w_mag;

        assign w_idx    = w_addr[k][c_QB-1:0];
        assign w_mirror = -w_idx;

        // odd quadrants read the table backwards; index 0 there is the peak
        always_comb begin
            w_mag = w_rom[w_idx];
            if (w_addr[k][c_QB]) begin
                w_mag = (w_idx == '0) ? c_PEAK : w_rom[w_mirror];
            end
        end

        assign w_val[k] = w_addr[k][LUT_ADDR-1] ? -w_mag : w_mag;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_cos <= '0;
            o_sin <= '0;
        end else if (i_en) begin
            o_cos <= w_val[0];
            o_sin <= w_val[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/nco_mixer.sv
`default_nettype none
// ============================================================================
// Module   : nco_mixer
// Brief    : NCO + quadrature mixer, 3-stage valid/ready pipeline.
//            Optional phase dither: define NCO_MIXER_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nco_mixer
    import nco_mixer_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int LUT_WIDTH   = c_LUT_WIDTH,
    parameter int PHASE_WIDTH = c_PHASE_WIDTH,
    parameter int LUT_ADDR    = c_LUT_ADDR
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic                   phase_clear,
    input  logic [DATA_WIDTH-1:0]  src_data_in,
    input  logic                   src_valid_in,
    output logic                   src_ready_out,
    output logic [DATA_WIDTH-1:0]  dst_data_i_out,
    output logic [DATA_WIDTH-1:0]  dst_data_q_out,
    output logic                   dst_valid_out,
    input  logic                   dst_ready_in
);

    localparam int c_PW = DATA_WIDTH + LUT_WIDTH + 1;
    localparam logic signed [c_PW-1:0] c_HALF = c_PW'(1) <<< (LUT_WIDTH - 2);
    localparam logic signed [c_PW-1:0] c_MAX  = (c_PW'(1) <<< (DATA_WIDTH - 1)) - c_PW'(1);
    localparam logic signed [c_PW-1:0] c_MIN  = -c_MAX - c_PW'(1);

    logic                   w_en;
    logic                   w_accept;
    logic [PHASE_WIDTH-1:0] r_acc;
    logic [LUT_ADDR-1:0]    w_addr;
    logic                   r_v1, r_v2, r_v3;
    logic [DATA_WIDTH-1:0]  r_x1, r_x2;
    logic [LUT_ADDR-1:0]    r_addr1;
    logic [LUT_WIDTH-1:0]   w_amp [2];
    logic [DATA_WIDTH-1:0]  w_y [2];
    logic [DATA_WIDTH-1:0]  r_y [2];

    assign w_en          = !r_v3 || dst_ready_in;
    assign w_accept      = src_valid_in && w_en;
    assign src_ready_out = w_en;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc <= '0;
        end else if (phase_clear) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= r_acc + freq_word;
        end
    end

`ifdef NCO_MIXER_DITHER_EN
    localparam logic [PHASE_WIDTH-1:0] c_DITHER_MASK =
        (PHASE_WIDTH'(1) << (PHASE_WIDTH - LUT_ADDR)) - PHASE_WIDTH'(1);

    lfsr_t                  r_lfsr;
    logic [PHASE_WIDTH-1:0] w_phase_sum;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & c_LFSR_TAPS)};
        end
    end

    assign w_phase_sum = r_acc + (PHASE_WIDTH'(r_lfsr) & c_DITHER_MASK);
    assign w_addr      = w_phase_sum[PHASE_WIDTH-1 -: LUT_ADDR];
`else
    assign w_addr = r_acc[PHASE_WIDTH-1 -: LUT_ADDR];
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_v1    <= 1'b0;
            r_x1    <= '0;
            r_addr1 <= '0;
            r_v2    <= 1'b0;
            r_x2    <= '0;
        end else if (w_en) begin
            r_v1    <= src_valid_in;
            r_x1    <= src_data_in;
            r_addr1 <= w_addr;
            r_v2    <= r_v1;
            r_x2    <= r_x1;
        end
    end

    sine_lut #(
        .LUT_WIDTH (LUT_WIDTH),
        .LUT_ADDR  (LUT_ADDR)
    ) u_sine_lut (
        .clk    (clk),
        .arst   (arst),
        .i_en   (w_en),
        .i_addr (r_addr1),
        .o_cos  (w_amp[0]),
        .o_sin  (w_amp[1])
    );

    // round half-up, drop LUT_WIDTH-1 fraction bits, clamp to DATA_WIDTH
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [c_PW-1:0] prod);
        logic signed [c_PW-1:0] v;
        logic signed [c_PW-1:0] res;
        v   = (prod + c_HALF) >>> (LUT_WIDTH - 1);
        res = v;
        if (v > c_MAX) begin
            res = c_MAX;
        end else if (v < c_MIN) begin
            res = c_MIN;
        end
        return res[DATA_WIDTH-1:0];
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_chan
        logic signed [c_PW-1:0] w_xe;
        logic signed [c_PW-1:0] w_ae;
        logic signed [c_PW-1:0] w_prod;

        assign w_xe   = {{(LUT_WIDTH+1){r_x2[DATA_WIDTH-1]}}, r_x2};
        assign w_ae   = {{(DATA_WIDTH+1){w_amp[k][LUT_WIDTH-1]}}, w_amp[k]};
        assign w_prod = w_xe * w_ae;
        assign w_y[k] = round_sat(w_prod);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_v3   <= 1'b0;
            r_y[0] <= '0;
            r_y[1] <= '0;
        end else if (w_en) begin
            r_v3   <= r_v2;
            r_y[0] <= w_y[0];
            r_y[1] <= w_y[1];
        end
    end

    assign dst_valid_out  = r_v3;
    assign dst_data_i_out = r_y[0];
    assign dst_data_q_out = r_y[1];

endmodule
`default_nettype wire

// File: tb/tb_nco_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_mixer
// Brief    : Directed scoreboard bench for nco_mixer at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_mixer;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
    } exp_t;

    logic        clk;
    logic        arst;
    logic [31:0] freq_word;
    logic        phase_clear;
    logic [15:0] src_data_in;
    logic        src_valid_in;
    logic        src_ready_out;
    logic [15:0] dst_data_i_out;
    logic [15:0] dst_data_q_out;
    logic        dst_valid_out;
    logic        dst_ready_in;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb [$];
    exp_t e_out;
    exp_t e_in;
    logic [31:0] m_acc;
    int   oct;
    // round(32767 * cos(k * 45 deg))
    int   cos_tab [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};

    nco_mixer u_dut (
        .clk            (clk),
        .arst           (arst),
        .freq_word      (freq_word),
        .phase_clear    (phase_clear),
        .src_data_in    (src_data_in),
        .src_valid_in   (src_valid_in),
        .src_ready_out  (src_ready_out),
        .dst_data_i_out (dst_data_i_out),
        .dst_data_q_out (dst_data_q_out),
        .dst_valid_out  (dst_valid_out),
        .dst_ready_in   (dst_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mix(input logic [15:0] x, input int a);
        longint p;
        p = longint'($signed(x)) * longint'(a) + 64'sd16384;
        p = p >>> 15;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic clr);
        @(posedge clk);
        #1;
        src_valid_in = v;
        src_data_in  = d;
        phase_clear  = clr;
    endtask

    // Scoreboard: expectations pushed on accepted input, popped on output transfer
    always @(negedge clk) begin
        if (arst) begin
            sb.delete();
            m_acc = '0;
        end else begin
            if (dst_valid_out && dst_ready_in) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL out_spurious got=valid expected=no_output");
                end
                if (sb.size() != 0) begin
                    e_out = sb.pop_front();
                    checks++;
                    assert (dst_data_i_out === e_out.i) else begin
                        failures++;
                        $error("FAIL out_i got=%h expected=%h", dst_data_i_out, e_out.i);
                    end
                    checks++;
                    assert (dst_data_q_out === e_out.q) else begin
                        failures++;
                        $error("FAIL out_q got=%h expected=%h", dst_data_q_out, e_out.q);
                    end
                end
            end
            if (src_valid_in && src_ready_out) begin
                oct    = int'(m_acc[31:29]);
                e_in.i = mix(src_data_in, cos_tab[oct]);
                e_in.q = mix(src_data_in, cos_tab[(oct + 6) % 8]);
                sb.push_back(e_in);
            end
            if (phase_clear) begin
                m_acc = '0;
            end else if (src_valid_in && src_ready_out) begin
                m_acc = m_acc + freq_word;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst         = 1'b1;
        freq_word    = '0;
        phase_clear  = 1'b0;
        src_data_in  = '0;
        src_valid_in = 1'b0;
        dst_ready_in = 1'b1;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(dst_valid_out), 32'd0);
        chk("rst_i", 32'(dst_data_i_out), 32'd0);
        chk("rst_q", 32'(dst_data_q_out), 32'd0);
        chk("rst_ready", 32'(src_ready_out), 32'd1);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // DC: freq 0, constant input
        for (int k = 0; k < 8; k++) step(1'b1, 16'h4000, 1'b0);

        // fs/4 rotation, then a 5-cycle downstream stall mid-stream
        freq_word = 32'h4000_0000;
        for (int k = 0; k < 8; k++) step(1'b1, 16'h4000, 1'b0);
        dst_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready", 32'(src_ready_out), 32'd0);
            chk("stall_valid", 32'(dst_valid_out), 32'd1);
            @(posedge clk);
            #1;
        end
        dst_ready_in = 1'b1;
        for (int k = 0; k < 6; k++) step(1'b1, 16'h4000, 1'b0);

        // 45-degree steps, varied data with bubbles
        freq_word = 32'h2000_0000;
        step(1'b1, 16'h7FFF, 1'b0);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'hEDCC, 1'b0);
        step(1'b0, 16'h5555, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'hC000, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);

        // full-scale inputs at cos peak
        freq_word = 32'h0;
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h7FFF, 1'b0);

        // phase_clear on an idle cycle, then coinciding with a transfer
        freq_word = 32'h4000_0000;
        for (int k = 0; k < 3; k++) step(1'b1, 16'h4000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4000, 1'b1);
        step(1'b1, 16'h4000, 1'b0);

        // reset with three samples in flight
        step(1'b1, 16'h2000, 1'b0);
        step(1'b1, 16'h3000, 1'b0);
        step(1'b1, 16'h5000, 1'b0);
        @(posedge clk);
        #1;
        src_valid_in = 1'b0;
        arst         = 1'b1;
        #1;
        chk("midrst_valid", 32'(dst_valid_out), 32'd0);
        chk("midrst_i", 32'(dst_data_i_out), 32'd0);
        chk("midrst_ready", 32'(src_ready_out), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);

        // random valid/ready traffic at 135-degree steps
        freq_word = 32'h6000_0000;
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            dst_ready_in = ($urandom_range(0, 3) != 0);
        end

        step(1'b0, 16'h0000, 1'b0);
        dst_ready_in = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nco_mixer.md
NCO_MIXER -- requirements
Module: nco_mixer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width; signed Q1.(DATA_WIDTH-1), matching the final DUC saturated output.
REQ-002 Parameter LUT_WIDTH, default 16, signed sine/cosine amplitude width.
REQ-003 Parameter PHASE_WIDTH, default 32, phase accumulator width.
REQ-004 Parameter LUT_ADDR, default 10, phase bits used to address a full period (2^LUT_ADDR points).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 arst  input  1  asynchronous, active-high reset.
REQ-007 freq_word  input  PHASE_WIDTH  phase increment per accepted sample, unsigned.
REQ-008 phase_clear  input  1  synchronous accumulator clear.
REQ-009 src_data_in  input  DATA_WIDTH  upstream real sample (DUC output).
REQ-010 src_valid_in  input  1  / src_ready_out  output  1  upstream valid/ready pair.
REQ-011 dst_data_i_out, dst_data_q_out  output  DATA_WIDTH each  x·cos(phi), x·sin(phi).
REQ-012 dst_valid_out  output  1  / dst_ready_in  input  1  downstream valid/ready pair.

Function
REQ-013 Transfer occurs on a cycle where valid and ready are both high, on either side.
REQ-014 Three-stage pipeline with a single advance enable en = !dst_valid_out || dst_ready_in; src_ready_out = en, combinational, no dependency on src_valid_in.
REQ-015 Latency: sample accepted in cycle N appears on dst_* in cycle N+3 given dst_ready_in held high; full throughput of one sample per cycle.
REQ-016 Stage 1: register sample and phase address = top LUT_ADDR bits of the accumulator value before the increment.
REQ-017 Accumulator adds freq_word only on an accepted input transfer; wraps modulo 2^PHASE_WIDTH; holds otherwise.
REQ-018 phase_clear high: accumulator becomes 0 next cycle; if it coincides with an accepted transfer, that sample uses the pre-clear phase and the next uses phase 0.
REQ-019 Stage 2: sine_lut returns cos and sin, registered; amplitude peak = 2^(LUT_WIDTH-1)-1, never -2^(LUT_WIDTH-1).
REQ-020 Stage 3: full-precision signed products (DATA_WIDTH+LUT_WIDTH bits), round half-up at bit LUT_WIDTH-2, shift right by LUT_WIDTH-1, saturate to DATA_WIDTH.
REQ-021 Valid bits propagate through each stage with data; an invalid slot never produces dst_valid_out.
REQ-022 dst_valid_out high with dst_ready_in low: all dst_* and all pipeline stages hold stable; no sample lost or duplicated.
REQ-023 freq_word change takes effect on the next accepted transfer; samples already in flight are unaffected.

Reset
REQ-024 arst high: all valid bits, accumulator, data and LUT registers clear to 0 immediately; dst_valid_out=0, dst_data_*=0, src_ready_out=1 (en=1).
REQ-025 Reset mid-stream discards all in-flight samples; first post-reset sample uses phase 0.

Configuration
REQ-026 Macro NCO_MIXER_DITHER_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1 on reset) advancing on each accepted transfer adds its low (PHASE_WIDTH-LUT_ADDR) bits to the address computation before truncation.
REQ-027 Macro undefined: no LFSR logic; plain truncation as REQ-016.

Structure
REQ-028 Package nco_mixer_pkg holds phase_t, sample_t, amp_t typedefs, LFSR seed/taps constants and the LUT quantisation function.
REQ-029 Sub-module sine_lut: quarter-wave table of 2^(LUT_ADDR-2) entries, quadrant folding, one registered cycle, enable input = en.

Verification (DATA_WIDTH=16, LUT_WIDTH=16, PHASE_WIDTH=32, LUT_ADDR=10, dither off)
REQ-030 freq_word=0, continuous src_data_in=0x4000, ready high -> from cycle 3 on, I=0x4000, Q=0x0000 every cycle.
REQ-031 freq_word=0x4000_0000, constant 0x4000 -> I repeats 0x4000,0x0000,0xC001,0x0000; Q repeats 0x0000,0x4000,0x0000,0xC001.
REQ-032 Same stimulus with dst_ready_in low for 5 cycles mid-stream -> outputs held, src_ready_out low while stalled, sequence resumes with no gap/duplicate.
REQ-033 Input 0x8000 with cos peak -> I=0x8001, no wrap; input 0x7FFF -> I=0x7FFE.
REQ-034 phase_clear pulsed after 3 samples at fs/4 -> fourth sample output I=0x4000 (phase 0).
REQ-035 arst asserted with 3 samples in flight -> dst_valid_out=0 same cycle; no stale sample appears after release.
